// File: rtl/i2c_main_seq_ctrl.sv
// i2c_main_seq_ctrl: I2C master main sequencer driving address/write/read engines and tap START/STOP commands
module i2c_main_seq_ctrl #(
   parameter int ALEN      = 7,
   parameter int LW        = 16,
   parameter int CSIZE     = 4,
   parameter int MAX_RETRY = 3,
   parameter int TMO_W     = 16,
   parameter int MODULE_ID = 0,
   parameter logic [CSIZE-1:0] CMD_START = CSIZE'(1),
   parameter logic [CSIZE-1:0] CMD_STOP  = CSIZE'(2)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [1:0]       cmd,
   input  logic             cmd_stop,
   input  logic             cmd_vld,
   output logic             cmd_ready,
   input  logic [ALEN-1:0]  addr,
   input  logic [LW-1:0]    wr_len,
   input  logic [LW-1:0]    rd_len,
   output logic             cmd_finish,
   output logic [1:0]       cmd_status,
   output logic             exec_addr,
   output logic             exec_addr_rw,
   output logic [ALEN-1:0]  address_curr,
   output logic [LW-1:0]    exec_len,
   input  logic             exec_addr_finish,
   input  logic             exec_ack_ok,
   output logic             exec_wr,
   input  logic             exec_wr_finish,
   output logic             exec_rd,
   input  logic             exec_rd_finish,
   output logic             tras_cmd_vld,
   output logic [CSIZE-1:0] tras_cmd,
   input  logic             tras_cmd_ready,
   output logic [3:0]       tras_cmd_mid,
   output logic [1:0]       tras_cmd_proc_id,
   output logic             fifo_rst
);
   localparam logic [3:0] S_IDLE = 4'd0, S_START = 4'd1, S_ADDR_W = 4'd2, S_WRITE = 4'd3,
                          S_RESTART = 4'd4, S_ADDR_R = 4'd5, S_READ = 4'd6, S_STOP = 4'd7,
                          S_DONE = 4'd8, S_FIFO_RST = 4'd9;
   localparam logic [1:0] C_READ = 2'd2, C_WTR = 2'd3;
   localparam logic [1:0] ST_OK = 2'd0, ST_NACK = 2'd1, ST_TMO = 2'd2;
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
   localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

   logic [3:0]       state, nxt;
   logic             ent, to, counting, tmo_exp, retry_go;
   logic [TMO_W-1:0] tmo;
   logic [1:0]       cmd_q, sts;
   logic             stop_q;
   logic [LW-1:0]    wr_len_q, rd_len_q;
   logic [RW-1:0]    retry;
   logic [3:0]       after_w, after_r;

   assign counting   = state inside {S_START, S_ADDR_W, S_WRITE, S_RESTART, S_ADDR_R, S_READ, S_STOP};
   assign tmo_exp    = counting && tmo == TMO_LAST;
   assign retry_go   = sts == ST_NACK && retry < RMAX;
   assign after_r    = stop_q ? S_STOP : S_DONE;
   assign after_w    = (cmd_q == C_WTR && rd_len_q != '0) ? S_RESTART : after_r;
   assign cmd_ready  = state == S_IDLE;
   assign cmd_finish = state == S_DONE;
   assign cmd_status = sts;
   assign fifo_rst   = state == S_FIFO_RST;
   assign exec_addr  = ent && (state == S_ADDR_W || state == S_ADDR_R);
   assign exec_wr    = ent && state == S_WRITE;
   assign exec_rd    = ent && state == S_READ;
   assign tras_cmd_vld = state == S_START || state == S_RESTART || state == S_STOP;
   assign tras_cmd     = state == S_STOP ? CMD_STOP : CMD_START;
   assign tras_cmd_mid = 4'(MODULE_ID);

   // next-state selection; a phase finish takes priority over a coincident timeout
   always_comb begin
      nxt = state;
      to  = 1'b0;
      case (state)
         S_IDLE:     if (cmd_vld) nxt = cmd == 2'd0 ? S_FIFO_RST : S_START;
         S_FIFO_RST: nxt = S_DONE;
         S_START, S_RESTART:
            if (tras_cmd_ready) nxt = (state == S_RESTART || cmd_q == C_READ) ? S_ADDR_R : S_ADDR_W;
            else if (tmo_exp) begin nxt = S_STOP; to = 1'b1; end
         S_ADDR_W:
            if (exec_addr_finish) nxt = !exec_ack_ok ? S_STOP : wr_len_q != '0 ? S_WRITE : after_w;
            else if (tmo_exp) begin nxt = S_STOP; to = 1'b1; end
         S_WRITE:
            if (exec_wr_finish) nxt = after_w;
            else if (tmo_exp) begin nxt = S_STOP; to = 1'b1; end
         S_ADDR_R:
            if (exec_addr_finish) nxt = !exec_ack_ok ? S_STOP : rd_len_q != '0 ? S_READ : after_r;
            else if (tmo_exp) begin nxt = S_STOP; to = 1'b1; end
         S_READ:
            if (exec_rd_finish) nxt = after_r;
            else if (tmo_exp) begin nxt = S_STOP; to = 1'b1; end
         S_STOP:
            if (tras_cmd_ready) nxt = retry_go ? S_START : S_DONE;
            else if (tmo_exp) begin nxt = S_DONE; to = 1'b1; end
         S_DONE:     nxt = S_IDLE;
         default:    nxt = S_IDLE;
      endcase
   end

   // state, per-phase timer, command latches, status/retry tracking and transaction id
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= S_IDLE;
         ent <= 1'b0;
         tmo <= '0;
         cmd_q <= '0;
         stop_q <= 1'b0;
         wr_len_q <= '0;
         rd_len_q <= '0;
         address_curr <= '0;
         exec_len <= '0;
         exec_addr_rw <= 1'b0;
         retry <= '0;
         sts <= ST_OK;
         tras_cmd_proc_id <= '0;
      end else begin
         state <= nxt;
         ent <= nxt != state;
         tmo <= (nxt != state || !counting) ? '0 : tmo + 1'b1;
         if (state == S_IDLE && cmd_vld) begin
            cmd_q <= cmd;
            stop_q <= cmd_stop;
            address_curr <= addr;
            wr_len_q <= wr_len;
            rd_len_q <= rd_len;
            retry <= '0;
            sts <= ST_OK;
         end
         if (nxt == S_ADDR_W) exec_addr_rw <= 1'b0;
         if (nxt == S_ADDR_R) exec_addr_rw <= 1'b1;
         if (nxt == S_WRITE) exec_len <= wr_len_q;
         if (nxt == S_READ) exec_len <= rd_len_q;
         if ((state == S_ADDR_W || state == S_ADDR_R) && exec_addr_finish && !exec_ack_ok) sts <= ST_NACK;
         if (to) sts <= ST_TMO;
         if (state == S_STOP && tras_cmd_ready && retry_go) begin
            retry <= retry + 1'b1;
            sts <= ST_OK;
         end
         if (state == S_DONE) tras_cmd_proc_id <= tras_cmd_proc_id + 2'd1;
      end
   end
endmodule
